m_dst_resolve_buf: RTL and testbench

- Write-back destination resolver for the M→W boundary, for loads whose real destination register depends on returned DM data.
- Queues in-flight M-stage write requests and resolves each request's true A3 when its in-order DM response arrives, using a per-entry mode.
- Emits a registered write-back triple (valid, A3, data) to the W stage.
- Gives the hazard unit a conservative "destination may be pending" query for any register address.

---
 rtl/m_dst_resolve_buf.sv | 138 +++++++++++++
 tb/tb_m_dst_resolve_buf.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/m_dst_resolve_buf.sv
// m_dst_resolve_buf: in-order queue of M-stage write requests. Each request's
// real destination is resolved from its DM response, using the mode stored with
// the entry. The buffer drives a registered write-back to W and answers a
// conservative "destination may be pending" query for the hazard unit.
module m_dst_resolve_buf #(
    parameter int AW       = 5,
    parameter int DW       = 32,
    parameter int DEPTH    = 4,
    parameter int ALT_LSB  = 0,
    parameter int COND_BIT = 31
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_valid,
    output logic                     push_ready,
    input  logic [AW-1:0]            push_a3,
    input  logic [1:0]               push_mode,
    input  logic                     rsp_valid,
    input  logic [DW-1:0]            rsp_data,
    input  logic                     flush,
    input  logic [AW-1:0]            q_a3,
    output logic                     q_hit,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     wb_valid,
    output logic [AW-1:0]            wb_a3,
    output logic [DW-1:0]            wb_data,
    output logic                     err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        MODE_FIXED    = 2'd0,
        MODE_DATA_DST = 2'd1,
        MODE_COND     = 2'd2,
        MODE_CHOOSE   = 2'd3
    } mode_e;

    logic [AW-1:0] a3_mem   [DEPTH];
    mode_e         mode_mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] cnt_q;
    // One extra bit: a second flush can land while earlier drops are still owed.
    logic [CW:0]   drop_cnt;

    logic          drop_hit;
    logic          pop;
    logic          rsp_orphan;
    logic          accept;
    logic [AW-1:0] alt;
    logic          cond;
    logic [AW-1:0] resolved;

    assign count      = cnt_q;
    assign push_ready = (cnt_q < CW'(DEPTH));
    assign drop_hit   = rsp_valid && (drop_cnt != '0);
    assign pop        = rsp_valid && (drop_cnt == '0) && (cnt_q != '0);
    assign rsp_orphan = rsp_valid && (drop_cnt == '0) && (cnt_q == '0);
    // A full buffer still takes a push when the oldest entry leaves in the same
    // cycle; the new entry lands behind the survivors so FIFO order is kept.
    assign accept     = push_valid && !flush && (push_ready || pop);
    assign alt        = rsp_data[ALT_LSB +: AW];
    assign cond       = rsp_data[COND_BIT];

    // Resolve the oldest entry's destination from its mode and the response
    always_comb begin
        resolved = a3_mem[rd_ptr];
        case (mode_mem[rd_ptr])
            MODE_FIXED:    resolved = a3_mem[rd_ptr];
            MODE_DATA_DST: resolved = alt;
            MODE_COND:     resolved = cond ? a3_mem[rd_ptr] : '0;
            MODE_CHOOSE:   resolved = cond ? a3_mem[rd_ptr] : alt;
            default:       resolved = a3_mem[rd_ptr];
        endcase
    end

    // Hazard query over live entries, excluding the one popped this cycle
    always_comb begin
        q_hit = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if ((CW'(i) < cnt_q) && !(i == 0 && pop) && (q_a3 != '0)) begin
                case (mode_mem[rd_ptr + PW'(i)])
                    MODE_FIXED, MODE_COND: begin
                        if (a3_mem[rd_ptr + PW'(i)] == q_a3) q_hit = 1'b1;
                    end
                    MODE_DATA_DST, MODE_CHOOSE: q_hit = 1'b1;
                    default: q_hit = 1'b1;
                endcase
            end
        end
    end

    // Entry storage; contents are only meaningful below the occupancy count
    always_ff @(posedge clk) begin
        if (accept) begin
            a3_mem[wr_ptr]   <= push_a3;
            mode_mem[wr_ptr] <= mode_e'(push_mode);
        end
    end

    // Pointers, occupancy, drop accounting, error flag and write-back register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            cnt_q    <= '0;
            drop_cnt <= '0;
            err      <= 1'b0;
            wb_valid <= 1'b0;
            wb_a3    <= '0;
            wb_data  <= '0;
        end else begin
            wb_valid <= pop && !flush;
            if (pop && !flush) begin
                wb_a3   <= resolved;
                wb_data <= rsp_data;
            end
            if (rsp_orphan) begin
                err <= 1'b1;
            end
            if (flush) begin
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                cnt_q    <= '0;
                drop_cnt <= drop_cnt - (CW+1)'(drop_hit)
                          + (CW+1)'(cnt_q) - (CW+1)'(pop);
            end else begin
                if (drop_hit) drop_cnt <= drop_cnt - 1'b1;
                if (pop)      rd_ptr   <= rd_ptr + 1'b1;
                if (accept)   wr_ptr   <= wr_ptr + 1'b1;
                cnt_q <= cnt_q + CW'(accept) - CW'(pop);
            end
        end
    end

endmodule

// File: tb/tb_m_dst_resolve_buf.sv
// Bench for m_dst_resolve_buf: a queue model predicts each write-back when a
// response is driven; a negedge monitor pops and compares the DUT write-backs.
module tb_m_dst_resolve_buf;

    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          push_valid;
    logic          push_ready;
    logic [AW-1:0] push_a3;
    logic [1:0]    push_mode;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;
    logic          flush;
    logic [AW-1:0] q_a3;
    logic          q_hit;
    logic [2:0]    count;
    logic          wb_valid;
    logic [AW-1:0] wb_a3;
    logic [DW-1:0] wb_data;
    logic          err;

    typedef struct {
        int            due;
        logic [AW-1:0] a3;
        logic [DW-1:0] d;
    } exp_t;

    typedef struct {
        logic [AW-1:0] a3;
        logic [1:0]    md;
    } ent_t;

    exp_t sb[$];
    ent_t mq[$];
    int   drop     = 0;
    bit   exp_err  = 1'b0;
    int   cyc      = 0;
    int   checks   = 0;
    int   failures = 0;

    m_dst_resolve_buf #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .ALT_LSB(0), .COND_BIT(31)) dut (
        .clk(clk), .reset(reset),
        .push_valid(push_valid), .push_ready(push_ready),
        .push_a3(push_a3), .push_mode(push_mode),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .flush(flush),
        .q_a3(q_a3), .q_hit(q_hit), .count(count),
        .wb_valid(wb_valid), .wb_a3(wb_a3), .wb_data(wb_data), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [AW-1:0] expect_a3(input ent_t e, input logic [DW-1:0] d);
        logic [AW-1:0] alt_f;
        alt_f = d[AW-1:0];
        case (e.md)
            2'd0:    return e.a3;
            2'd1:    return alt_f;
            2'd2:    return d[31] ? e.a3 : 5'd0;
            default: return d[31] ? e.a3 : alt_f;
        endcase
    endfunction

    // Scoreboard monitor: every write-back must match the oldest prediction, on time
    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].due < cyc) begin
            checks++; failures++;
            $display("FAIL wb_missing: wb_valid=%0b required 1 (a3=%0d)", wb_valid, sb[0].a3);
            void'(sb.pop_front());
        end
        if (wb_valid === 1'b1) begin
            checks++;
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                if (wb_a3 !== e.a3 || wb_data !== e.d) begin
                    failures++;
                    $display("FAIL wb_triple: got a3=%0d data=%h required a3=%0d data=%h", wb_a3, wb_data, e.a3, e.d);
                end
            end else begin
                failures++;
                $display("FAIL wb_unexpected: wb_valid=1 a3=%0d required no write-back", wb_a3);
            end
        end
    end

    // One clock of stimulus; the model is updated as the stimulus is applied
    task automatic drive(input bit pv, input logic [AW-1:0] a3, input logic [1:0] md,
                         input bit rv, input logic [DW-1:0] d, input bit fl);
        int   sz;
        bit   acc;
        ent_t e;
        push_valid = pv; push_a3 = a3; push_mode = md;
        rsp_valid = rv; rsp_data = d; flush = fl;
        sz  = mq.size();
        acc = pv && !fl && (sz < DEPTH || (rv && drop == 0 && sz > 0));
        if (rv) begin
            if (drop > 0) drop--;
            else if (sz > 0) begin
                e = mq.pop_front();
                if (!fl) sb.push_back('{cyc + 1, expect_a3(e, d), d});
            end else exp_err = 1'b1;
        end
        if (fl) begin
            drop += mq.size();
            mq.delete();
        end else if (acc) begin
            mq.push_back('{a3, md});
        end
        @(posedge clk);
        @(negedge clk);
        push_valid = 1'b0; rsp_valid = 1'b0; flush = 1'b0;
    endtask

    task automatic idle();
        drive(1'b0, '0, 2'd0, 1'b0, '0, 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b0; push_valid = 1'b0; push_a3 = '0; push_mode = '0;
        rsp_valid = 1'b0; rsp_data = '0; flush = 1'b0; q_a3 = 5'd5;
        #12;
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL rst_count: got %0d required 0", count); end
        checks++; if (wb_valid !== 1'b0 || wb_a3 !== '0 || wb_data !== '0) begin failures++; $display("FAIL rst_wb: got %0b/%0d/%h required 0/0/0", wb_valid, wb_a3, wb_data); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL rst_err: got %0b required 0", err); end
        checks++; if (push_ready !== 1'b1 || q_hit !== 1'b0) begin failures++; $display("FAIL rst_ready_hit: got %0b/%0b required 1/0", push_ready, q_hit); end
        @(negedge clk);
        reset = 1'b1;
        idle();
    endtask

    task automatic test_fixed();
        drive(1'b1, 5'd8, 2'd0, 1'b0, '0, 1'b0);
        checks++; if (count !== 3'd1) begin failures++; $display("FAIL fixed_count1: got %0d required 1", count); end
        drive(1'b0, '0, 2'd0, 1'b1, 32'h1234, 1'b0);
        checks++; if (wb_valid !== 1'b1 || wb_a3 !== 5'd8 || wb_data !== 32'h1234) begin failures++; $display("FAIL fixed_wb: got %0b/%0d/%h required 1/8/1234", wb_valid, wb_a3, wb_data); end
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL fixed_count0: got %0d required 0", count); end
        idle();
        checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL fixed_wb_drop: got %0b required 0", wb_valid); end
    endtask

    task automatic test_data_dst();
        drive(1'b1, 5'd3, 2'd1, 1'b0, '0, 1'b0);
        q_a3 = 5'd17; #1;
        checks++; if (q_hit !== 1'b1) begin failures++; $display("FAIL dd_qhit: got %0b required 1", q_hit); end
        q_a3 = 5'd0; #1;
        checks++; if (q_hit !== 1'b0) begin failures++; $display("FAIL dd_qhit_zero: got %0b required 0", q_hit); end
        drive(1'b0, '0, 2'd0, 1'b1, 32'h0000_0011, 1'b0);
        checks++; if (wb_a3 !== 5'd17) begin failures++; $display("FAIL dd_wb_a3: got %0d required 17", wb_a3); end
    endtask

    task automatic test_cond_choose();
        drive(1'b1, 5'd9, 2'd2, 1'b0, '0, 1'b0);
        drive(1'b1, 5'd9, 2'd3, 1'b0, '0, 1'b0);
        q_a3 = 5'd12; #1;
        checks++; if (q_hit !== 1'b1) begin failures++; $display("FAIL cc_qhit_choose: got %0b required 1", q_hit); end
        drive(1'b0, '0, 2'd0, 1'b1, 32'h8000_0005, 1'b0);
        drive(1'b0, '0, 2'd0, 1'b1, 32'h0000_0006, 1'b0);
        checks++; if (wb_a3 !== 5'd6) begin failures++; $display("FAIL cc_choose_alt: got %0d required 6", wb_a3); end
        drive(1'b1, 5'd9, 2'd2, 1'b0, '0, 1'b0);
        drive(1'b0, '0, 2'd0, 1'b1, 32'h0000_0000, 1'b0);
        checks++; if (wb_valid !== 1'b1 || wb_a3 !== 5'd0) begin failures++; $display("FAIL cc_cond_zero: got %0b/%0d required 1/0", wb_valid, wb_a3); end
    endtask

    task automatic test_full();
        for (int i = 1; i <= 4; i++) drive(1'b1, AW'(i), 2'd0, 1'b0, '0, 1'b0);
        checks++; if (count !== 3'd4 || push_ready !== 1'b0) begin failures++; $display("FAIL full_state: got count=%0d ready=%0b required 4/0", count, push_ready); end
        drive(1'b1, 5'd6, 2'd0, 1'b0, '0, 1'b0);
        q_a3 = 5'd6; #1;
        checks++; if (count !== 3'd4 || q_hit !== 1'b0) begin failures++; $display("FAIL full_ignored: got count=%0d qhit=%0b required 4/0", count, q_hit); end
        rsp_valid = 1'b1; q_a3 = 5'd1; #1;
        checks++; if (q_hit !== 1'b0) begin failures++; $display("FAIL full_popped_excluded: got %0b required 0", q_hit); end
        q_a3 = 5'd2; #1;
        checks++; if (q_hit !== 1'b1) begin failures++; $display("FAIL full_next_hit: got %0b required 1", q_hit); end
        rsp_valid = 1'b0;
        drive(1'b1, 5'd5, 2'd0, 1'b1, 32'h0000_000A, 1'b0);
        checks++; if (count !== 3'd4) begin failures++; $display("FAIL full_push_rsp: got %0d required 4", count); end
        for (int i = 0; i < 4; i++) drive(1'b0, '0, 2'd0, 1'b1, DW'(32'h100 + i), 1'b0);
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL full_drain: got %0d required 0", count); end
    endtask

    task automatic test_flush();
        drive(1'b1, 5'd10, 2'd0, 1'b0, '0, 1'b0);
        drive(1'b1, 5'd11, 2'd0, 1'b0, '0, 1'b0);
        drive(1'b1, 5'd12, 2'd0, 1'b0, '0, 1'b0);
        drive(1'b1, 5'd13, 2'd0, 1'b1, 32'hAAAA, 1'b1);
        checks++; if (count !== 3'd0 || wb_valid !== 1'b0) begin failures++; $display("FAIL flush_state: got count=%0d wb=%0b required 0/0", count, wb_valid); end
        drive(1'b0, '0, 2'd0, 1'b1, 32'hBBBB, 1'b0);
        drive(1'b1, 5'd4, 2'd0, 1'b1, 32'hCCCC, 1'b0);
        checks++; if (wb_valid !== 1'b0 || count !== 3'd1) begin failures++; $display("FAIL flush_dropped: got wb=%0b count=%0d required 0/1", wb_valid, count); end
        drive(1'b0, '0, 2'd0, 1'b1, 32'h4444, 1'b0);
        checks++; if (wb_a3 !== 5'd4 || err !== 1'b0) begin failures++; $display("FAIL flush_after: got a3=%0d err=%0b required 4/0", wb_a3, err); end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 5'd20, 2'd0, 1'b0, '0, 1'b0);
        drive(1'b1, 5'd2,  2'd1, 1'b0, '0, 1'b0);
        drive(1'b1, 5'd21, 2'd3, 1'b0, '0, 1'b0);
        drive(1'b0, '0,    2'd0, 1'b1, 32'h0000_0015, 1'b0);
        drive(1'b1, 5'd22, 2'd0, 1'b1, 32'h0000_0007, 1'b0);
        checks++; if (count !== 3'd2) begin failures++; $display("FAIL b2b_count: got %0d required 2", count); end
        drive(1'b0, '0, 2'd0, 1'b1, 32'h8000_0003, 1'b0);
        drive(1'b0, '0, 2'd0, 1'b1, 32'h0000_0019, 1'b0);
        idle();
        checks++; if (count !== 3'd0 || err !== exp_err) begin failures++; $display("FAIL b2b_end: got count=%0d err=%0b required 0/%0b", count, err, exp_err); end
    endtask

    task automatic test_err_async();
        drive(1'b0, '0, 2'd0, 1'b1, 32'h1, 1'b0);
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_set: got %0b required 1", err); end
        idle();
        checks++; if (err !== 1'b1 || wb_valid !== 1'b0) begin failures++; $display("FAIL err_sticky: got err=%0b wb=%0b required 1/0", err, wb_valid); end
        drive(1'b1, 5'd7, 2'd0, 1'b0, '0, 1'b0);
        rsp_valid = 1'b1; rsp_data = 32'h77;
        @(posedge clk); #1;
        rsp_valid = 1'b0;
        checks++; if (wb_valid !== 1'b1 || wb_a3 !== 5'd7) begin failures++; $display("FAIL async_pre: got wb=%0b a3=%0d required 1/7", wb_valid, wb_a3); end
        #1 reset = 1'b0;
        q_a3 = 5'd7; #1;
        checks++; if (wb_valid !== 1'b0 || wb_a3 !== '0 || wb_data !== '0 || err !== 1'b0 || count !== 3'd0 || q_hit !== 1'b0) begin
            failures++; $display("FAIL async_reset: got wb=%0b a3=%0d data=%h err=%0b count=%0d qhit=%0b required all 0", wb_valid, wb_a3, wb_data, err, count, q_hit);
        end
        mq.delete(); drop = 0; exp_err = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        idle();
        checks++; if (err !== 1'b0 || count !== 3'd0) begin failures++; $display("FAIL post_reset: got err=%0b count=%0d required 0/0", err, count); end
    endtask

    initial begin
        test_reset();
        test_fixed();
        test_data_dst();
        test_cond_choose();
        test_full();
        test_flush();
        test_back_to_back();
        test_err_async();
        idle();
        idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
